pmem_arbiter: RTL

//  Shares one physical-memory port (256-bit line, pmem_* handshake) between the I-cache and D-cache miss paths.

---
 rtl/pmem_arb_pkg.sv | 5 +
 rtl/pmem_arbiter_if.sv | 11 +
 rtl/pmem_arbiter_rr_pick2.sv | 8 +
 rtl/pmem_arbiter.sv | 48 ++++
 4 files changed

// File: rtl/pmem_arb_pkg.sv
// pmem_arb_pkg: shared state and grant types for the physical-memory arbiter
package pmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
  typedef enum logic {GNT_I, GNT_D} grant_t;
endpackage

// File: rtl/pmem_arbiter_if.sv
// pmem_arbiter_if: one line-transfer channel; master issues requests, slave answers with data and resp
interface pmem_arbiter_if #(parameter int s_line = 256, parameter int s_addr = 32);
  logic [s_addr-1:0] address;
  logic read;
  logic write;
  logic [s_line-1:0] wdata;
  logic [s_line-1:0] rdata;
  logic resp;
  modport master (output address, read, write, wdata, input rdata, resp);
  modport slave (input address, read, write, wdata, output rdata, resp);
endinterface

// File: rtl/pmem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker; req[0] is the I side, req[1] the D side
module rr_pick2 import pmem_arb_pkg::*; (
  input  logic [1:0] req,
  input  grant_t     last,
  output grant_t     winner
);
  always_comb winner = req == 2'b01 ? GNT_I : req == 2'b10 ? GNT_D : last == GNT_I ? GNT_D : GNT_I;
endmodule

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one line-wide memory port between I-cache and D-cache, one whole line at a time
module pmem_arbiter import pmem_arb_pkg::*; #(
  parameter int s_line  = 256,
  parameter int s_addr  = 32,
  parameter bit D_FIRST = 1'b1
) (
  input logic clk,
  input logic rst,
  pmem_arbiter_if.slave  i_bus,
  pmem_arbiter_if.slave  d_bus,
  pmem_arbiter_if.master mem
);
  arb_state_t state_q, state_d;
  grant_t last_q, last_d, winner;
  logic sel_i, sel_d, any_req;
  rr_pick2 u_pick (.req({d_bus.read | d_bus.write, i_bus.read}), .last(last_q), .winner(winner));
  assign sel_i = state_q == SERVE_I;
  assign sel_d = state_q == SERVE_D;
  assign any_req = i_bus.read | d_bus.read | d_bus.write;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    if (state_q == IDLE) begin
      if (any_req) state_d = winner == GNT_I ? SERVE_I : SERVE_D;
    end else if (mem.resp) begin
      state_d = IDLE;
      last_d = sel_i ? GNT_I : GNT_D;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= D_FIRST ? GNT_I : GNT_D;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
    end
  end
  // the I side is read-only, so its write strobe and data never reach memory
  assign mem.address = sel_i ? i_bus.address : sel_d ? d_bus.address : s_addr'(0);
  assign mem.read = sel_i ? i_bus.read : sel_d & d_bus.read;
  assign mem.write = sel_d & d_bus.write;
  assign mem.wdata = sel_d ? d_bus.wdata : s_line'(0);
  assign i_bus.rdata = mem.rdata;
  assign d_bus.rdata = mem.rdata;
  assign i_bus.resp = sel_i & mem.resp;
  assign d_bus.resp = sel_d & mem.resp;
endmodule
